// File: rtl/stft_ram_reader_if.sv
// stft_ram_reader_if: read port of the banked spectrogram RAM
//   master (display reader): drives rd_en, bank_rd (one-hot), addr_rd; receives rd_data
//   slave  (RAM):            receives the strobe/select/address; drives rd_data
//   rd_data packs one 4-bit magnitude per bank, bank b at bits [4b+3:4b]
interface stft_ram_reader_if #(
    parameter int NO_BANKS      = 2,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     rd_en;
    logic [NO_BANKS-1:0]      bank_rd;
    logic [ADDRESS_WIDTH-1:0] addr_rd;
    logic [4*NO_BANKS-1:0]    rd_data;
    modport master (output rd_en, bank_rd, addr_rd, input rd_data);
    modport slave  (input rd_en, bank_rd, addr_rd, output rd_data);
endinterface

// File: rtl/stft_ram_reader.sv
// stft_ram_reader: display-side reader turning pixel coordinates into RAM reads and RGB565 pixels
//   clk, reset         pixel clock, synchronous active-high reset
//   oldest_fft_idx_i   writer's oldest-column pointer, latched on frame_start_i
//   frame_start_i      one-cycle pulse before the first pixel of a frame
//   pix_valid_i, x_i, y_i  pixel coordinate stream
//   ram                RAM read port (master modport)
//   rgb_valid_o, rgb_o pixel output, exactly 3 cycles after pix_valid_i
//   Macro HEATMAP_PALETTE_EN selects a heatmap ROM palette instead of grayscale.
module stft_ram_reader #(
    parameter int          FFT_SIZE      = 256,
    parameter int          NO_FFTS       = 50,
    parameter int          ADDRESS_WIDTH = 12,
    parameter int          NO_BANKS      = 2,
    parameter int          X_SHIFT       = 2,
    parameter int          Y_SHIFT       = 1,
    parameter int          COORD_WIDTH   = 10,
    parameter logic [15:0] BORDER_RGB    = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(NO_FFTS)-1:0] oldest_fft_idx_i,
    input  logic                       frame_start_i,
    input  logic                       pix_valid_i,
    input  logic [COORD_WIDTH-1:0]     x_i,
    input  logic [COORD_WIDTH-1:0]     y_i,
    stft_ram_reader_if.master          ram,
    output logic                       rgb_valid_o,
    output logic [15:0]                rgb_o
);
    localparam int PW = $clog2(NO_FFTS);
    localparam int BW = $clog2(FFT_SIZE/2);
    localparam int LW = PW + BW;
    localparam int KW = NO_BANKS > 1 ? $clog2(NO_BANKS) : 1;
`ifdef HEATMAP_PALETTE_EN
    localparam logic [15:0] HEAT [16] = '{
        16'h0000, 16'h0006, 16'h000C, 16'h0013, 16'h0019, 16'h001F, 16'h3019, 16'h6013,
        16'h980C, 16'hC806, 16'hF800, 16'hFAA0, 16'hFD40, 16'hFFE0, 16'hFFF0, 16'hFFFF
    };
`endif
    logic [PW-1:0]            lptr_q, lptr_d, fidx0_q, fidx0_d;
    logic [BW-1:0]            bin0_q, bin0_d;
    logic                     v0_q, in0_q, in0_d, v1_q, in1_q;
    logic [COORD_WIDTH-1:0]   col, row;
    logic [PW:0]              diff;
    logic [LW-1:0]            lin;
    logic [KW-1:0]            bk_d, bk1_q;
    logic                     rd_en_q, rd_en_d;
    logic [NO_BANKS-1:0]      bank_q, bank_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]               nib;
    logic [15:0]              pal, rgb_q, rgb_d;
    logic                     rgb_valid_q;
    always_comb begin
        // a frame_start coinciding with a pixel already uses the new pointer
        lptr_d  = frame_start_i ? oldest_fft_idx_i : lptr_q;
        col     = x_i >> X_SHIFT;
        row     = y_i >> Y_SHIFT;
        in0_d   = (col < COORD_WIDTH'(NO_FFTS)) && (row < COORD_WIDTH'(FFT_SIZE/2));
        bin0_d  = BW'(FFT_SIZE/2 - 1) - row[BW-1:0];
        // one extra bit so a negative difference is seen before wrapping
        diff    = {1'b0, lptr_d} - {1'b0, col[PW-1:0]};
        fidx0_d = diff[PW] ? PW'(diff + (PW+1)'(NO_FFTS)) : diff[PW-1:0];
        // same linear layout as the writer: column-major, bins contiguous
        lin     = {fidx0_q, bin0_q};
        bk_d    = KW'(lin >> ADDRESS_WIDTH);
        rd_en_d = v0_q && in0_q;
        bank_d  = rd_en_d ? NO_BANKS'(1) << bk_d : '0;
        addr_d  = rd_en_d ? lin[ADDRESS_WIDTH-1:0] : addr_q;
        nib     = ram.rd_data[4*bk1_q +: 4];
`ifdef HEATMAP_PALETTE_EN
        pal     = HEAT[nib];
`else
        pal     = {nib, nib[3], nib, nib[3:2], nib, nib[3]};
`endif
        rgb_d   = v1_q ? (in1_q ? pal : BORDER_RGB) : rgb_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lptr_q      <= '0;
            v0_q        <= 1'b0;
            in0_q       <= 1'b0;
            fidx0_q     <= '0;
            bin0_q      <= '0;
            v1_q        <= 1'b0;
            in1_q       <= 1'b0;
            bk1_q       <= '0;
            rd_en_q     <= 1'b0;
            bank_q      <= '0;
            addr_q      <= '0;
            rgb_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            lptr_q      <= lptr_d;
            v0_q        <= pix_valid_i;
            in0_q       <= in0_d;
            fidx0_q     <= fidx0_d;
            bin0_q      <= bin0_d;
            v1_q        <= v0_q;
            in1_q       <= in0_q;
            bk1_q       <= bk_d;
            rd_en_q     <= rd_en_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            rgb_valid_q <= v1_q;
            rgb_q       <= rgb_d;
        end
    end
    assign ram.rd_en   = rd_en_q;
    assign ram.bank_rd = bank_q;
    assign ram.addr_rd = addr_q;
    assign rgb_valid_o = rgb_valid_q;
    assign rgb_o       = rgb_q;
    // pointer values at or beyond NO_FFTS have no column to map to
    ptr_range: assert property (@(posedge clk) disable iff (reset)
        frame_start_i |-> ({1'b0, oldest_fft_idx_i} < (PW+1)'(NO_FFTS)));
endmodule

// File: tb/tb_stft_ram_reader.sv
// tb_stft_ram_reader: scoreboard bench for the spectrogram display reader
module tb_stft_ram_reader;
    logic        clk = 1'b0, reset = 1'b1, frame_start = 1'b0, pix_valid = 1'b0;
    logic [5:0]  oldest = '0;
    logic [9:0]  x = '0, y = '0;
    logic        rgb_valid;
    logic [15:0] rgb;
    int cyc = 0, checks = 0, errors = 0, lptr_m = 0;
    typedef struct {int cyc; int bank; int addr; logic [15:0] rgb;} exp_t;
    exp_t rdq[$], rgbq[$];
    stft_ram_reader_if #(.NO_BANKS(2), .ADDRESS_WIDTH(12)) ram_if ();
    stft_ram_reader dut (
        .clk(clk), .reset(reset), .oldest_fft_idx_i(oldest), .frame_start_i(frame_start),
        .pix_valid_i(pix_valid), .x_i(x), .y_i(y), .ram(ram_if),
        .rgb_valid_o(rgb_valid), .rgb_o(rgb)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // RAM contents: bank 0 returns addr[3:0], bank 1 returns addr[3:0]^4'hA
    assign ram_if.rd_data = {ram_if.addr_rd[3:0] ^ 4'hA, ram_if.addr_rd[3:0]};
    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask
    function automatic void model(input int lp, input int xx, input int yy, output bit ins,
                                  output int bank, output int addr, output logic [15:0] c);
        int col, r, l;
        logic [11:0] a;
        logic [3:0] d;
        col = xx / 4;
        r = yy / 2;
        ins = (col < 50) && (r < 128);
        bank = 0;
        addr = 0;
        c = 16'h0000;
        if (ins) begin
            l = ((lp - col + 50) % 50) * 128 + (127 - r);
            bank = l / 4096;
            addr = l % 4096;
            a = 12'(addr);
            d = (bank == 1) ? (a[3:0] ^ 4'hA) : a[3:0];
            c = {d, d[3], d, d[3:2], d, d[3]};
        end
    endfunction
    task automatic drive(input bit fs, input int ptr, input bit pv, input int xx, input int yy,
                         input bit push = 1'b1);
        bit ins;
        int bk, ad;
        logic [15:0] c;
        frame_start = fs;
        oldest = 6'(ptr);
        pix_valid = pv;
        x = 10'(xx);
        y = 10'(yy);
        if (fs) lptr_m = ptr;
        if (pv && push) begin
            model(lptr_m, xx, yy, ins, bk, ad, c);
            if (ins) rdq.push_back('{cyc + 2, bk, ad, 16'h0});
            rgbq.push_back('{cyc + 3, 0, 0, c});
        end
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (ram_if.rd_en) begin
                if (rdq.size() == 0) chk("rd_unexpected", int'(ram_if.rd_en), 0);
                else begin
                    e = rdq.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("bank_rd", int'(ram_if.bank_rd), 1 << e.bank);
                    chk("addr_rd", int'(ram_if.addr_rd), e.addr);
                end
            end else chk("bank_idle", int'(ram_if.bank_rd), 0);
            if (rgb_valid) begin
                if (rgbq.size() == 0) chk("rgb_unexpected", int'(rgb_valid), 0);
                else begin
                    e = rgbq.pop_front();
                    chk("rgb_cycle", cyc, e.cyc);
                    chk("rgb", int'(rgb), int'(e.rgb));
                end
            end
        end
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(ram_if.rd_en), 0);
        chk("rst_bank", int'(ram_if.bank_rd), 0);
        chk("rst_addr", int'(ram_if.addr_rd), 0);
        chk("rst_rgb_valid", int'(rgb_valid), 0);
        chk("rst_rgb", int'(rgb), 0);
        reset = 1'b0;
        drive(0, 0, 1, 0, 0);
        drive(1, 10, 1, 0, 254);
        drive(0, 10, 1, 196, 254);
        drive(0, 10, 0, 0, 0);
        drive(1, 40, 1, 0, 244);
        drive(1, 3, 1, 40, 0);
        drive(0, 20, 1, 40, 0);
        drive(0, 20, 1, 200, 0);
        drive(0, 20, 1, 0, 256);
        drive(0, 20, 0, 0, 0);
        drive(0, 20, 0, 0, 0);
        drive(1, 25, 1, 0, 0);
        for (int i = 1; i < 64; i++) drive(0, 25, 1, i * 4, i * 2);
        repeat (4) drive(0, 25, 0, 0, 0);
        chk("rdq_drained", rdq.size(), 0);
        chk("rgbq_drained", rgbq.size(), 0);
        drive(0, 25, 1, 4, 4, 1'b0);
        drive(0, 25, 1, 8, 4, 1'b0);
        reset = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_rd_en", int'(ram_if.rd_en), 0);
        chk("flush_bank", int'(ram_if.bank_rd), 0);
        chk("flush_addr", int'(ram_if.addr_rd), 0);
        chk("flush_rgb_valid", int'(rgb_valid), 0);
        chk("flush_rgb", int'(rgb), 0);
        reset = 1'b0;
        lptr_m = 0;
        repeat (5) drive(0, 0, 0, 0, 0);
        drive(0, 30, 1, 0, 0);
        repeat (5) drive(0, 30, 0, 0, 0);
        chk("rdq_final", rdq.size(), 0);
        chk("rgbq_final", rgbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
